id_ex_hazard_reg: RTL and testbench
===================================

# id_ex_hazard_reg

ID/EX pipeline register with integrated load-use hazard detection for the five-stage RV32 core. It sits directly downstream of the main decoder and register file. It latches the decoder's control bundle, operands, immediate and register addresses into the EX stage, and inserts a one-cycle bubble when the instruction in ID reads a register still being loaded by the `lw` in EX. It also drives the PC and IF/ID write enables that freeze the front end during that bubble.

## Interface
- `DATA_W`, 32, operand/immediate width
- `REG_W`, 5, register address width
- `clk_i` in 1: clock, rising edge
- `rst_i` in 1: reset, asynchronous, active-low
- `start_i` in 1: leaves IDLE when high
- `op_i` in 7: opcode of the instruction in ID
- `ALUOp_i` in 2, `ALUSrc_i`, `Branch_i`, `MemRead_i`, `MemWrite_i`, `RegWrite_i`, `MemtoReg_i` in 1 each: decoder control bundle
- `rs1_data_i`, `rs2_data_i`, `imm_i` in DATA_W: ID operands and sign-extended immediate
- `funct_i` in 10: {funct7, funct3}
- `rs1_addr_i`, `rs2_addr_i`, `rd_addr_i` in REG_W: ID register fields
- `flush_i` in 1: kill the instruction currently in ID
- `ex_ALUOp_o` out 2, `ex_ALUSrc_o`, `ex_Branch_o`, `ex_MemRead_o`, `ex_MemWrite_o`, `ex_RegWrite_o`, `ex_MemtoReg_o` out 1 each: registered control
- `ex_rs1_data_o`, `ex_rs2_data_o`, `ex_imm_o` out DATA_W; `ex_funct_o` out 10; `ex_rs1_addr_o`, `ex_rs2_addr_o`, `ex_rd_addr_o` out REG_W: registered datapath fields
- `stall_o` out 1: a bubble is being inserted this cycle
- `pc_write_o`, `ifid_write_o` out 1: front-end write enables

## Operation
- FSM states: IDLE, RUN, STALL.
  - IDLE → RUN on `start_i`=1.
  - RUN → STALL when `hazard`=1.
  - STALL → RUN unconditionally.
  - Reset → IDLE.
- `rs2_used` = 1 for `op_i` ∈ {0110011, 0100011, 1100011}; 0 otherwise. `rs1` is treated as used for every opcode.
- `hazard` = (state==RUN) & `ex_MemRead_o` & (`ex_rd_addr_o`≠0) & ((`ex_rd_addr_o`==`rs1_addr_i`) | (`rs2_used` & `ex_rd_addr_o`==`rs2_addr_i`)) & !`flush_i`.
- `stall_o` = `hazard`.
- `pc_write_o` = `ifid_write_o` = (state≠IDLE) & !`hazard`.
- Register update at each rising edge:
  - IDLE, `hazard`, or `flush_i`: all seven `ex_*` control outputs load 0 (bubble). Datapath fields load their inputs; they are don't-care under a bubble but must be deterministic.
  - Otherwise: every `ex_*` output loads its corresponding input.
- STALL state: detection is suppressed, because EX holds the bubble, and the ID instruction advances normally.
- `flush_i` together with a hazard condition: flush wins. No stall, bubble inserted, state stays RUN.
- Reset asserted mid-operation: all `ex_*` outputs 0 immediately (asynchronous); state IDLE; `pc_write_o`=`ifid_write_o`=0 until `start_i`.

## Timing
- Hazard detection and `stall_o`/`pc_write_o`/`ifid_write_o` are combinational in the same cycle the dependent instruction sits in ID.
- The bubble appears on the `ex_*` outputs after the next rising edge.
- The front end is held for exactly one edge per load-use pair.
- The stalled instruction is latched into EX one edge after the bubble. Total added latency: 1 cycle.
- Non-hazard path latency: 1 cycle, input to `ex_*`.
- Reset value of every registered output: 0. Combinational outputs evaluate to 0 in IDLE.

## Configuration
- `HAZARD_STALL_CNT_EN` defined:
  - Adds output `stall_cnt_o` (32 bits).
  - Increments on each RUN→STALL transition and saturates at 0xFFFFFFFF.
  - Cleared by reset; not cleared by `flush_i`.
- `HAZARD_STALL_CNT_EN` undefined: the port and the counter are absent; all other behaviour is identical.

## Test plan
- Reset and start: pulse `rst_i` low while in RUN with `ex_RegWrite_o`=1 → all `ex_*`=0 immediately, `pc_write_o`=0. `start_i`=1 → `pc_write_o`=1 in the following cycle.
- Load-use: EX holds `lw` with `ex_MemRead_o`=1, `ex_rd_addr_o`=5; ID holds `add` (op 0110011) with `rs1_addr_i`=5.
  - That cycle: `stall_o`=1, `pc_write_o`=`ifid_write_o`=0.
  - Next edge: all `ex_*` controls 0 and `stall_o`=0.
  - Following edge: `ex_RegWrite_o`=1, `ex_rs1_addr_o`=5.
- x0 and rs2 usage:
  - `lw` with `ex_rd_addr_o`=0 and ID `rs1_addr_i`=0 → `stall_o`=0.
  - `addi` (op 0010011) with `rs2_addr_i`=5 against `ex_rd_addr_o`=5 → `stall_o`=0.
  - `sw` (op 0100011) with `rs2_addr_i`=5 → `stall_o`=1.
- Flush priority: load-use condition present with `flush_i`=1 → `stall_o`=0, `pc_write_o`=1, bubble in EX after the edge, state remains RUN.
- Back-to-back loads: `lw` x5 followed by `lw` x6 that uses x5, then `add` using x6 → exactly two single-cycle stalls, no stall in the STALL-state cycles.
- With `HAZARD_STALL_CNT_EN` defined: three separate load-use pairs → `stall_cnt_o`=3. After reset → `stall_cnt_o`=0.

Source files
------------

// File: rtl/id_ex_hazard_reg_if.sv
// ID->EX stage bundle: decoder outputs into the hazard register and the
// registered EX fields plus front-end write enables coming back out.
interface id_ex_hazard_reg_if #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
);
   logic              start_i;
   logic [6:0]        op_i;
   logic [1:0]        ALUOp_i;
   logic              ALUSrc_i, Branch_i, MemRead_i, MemWrite_i, RegWrite_i, MemtoReg_i;
   logic [DATA_W-1:0] rs1_data_i, rs2_data_i, imm_i;
   logic [9:0]        funct_i;
   logic [REG_W-1:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
   logic              flush_i;

   logic [1:0]        ex_ALUOp_o;
   logic              ex_ALUSrc_o, ex_Branch_o, ex_MemRead_o, ex_MemWrite_o, ex_RegWrite_o, ex_MemtoReg_o;
   logic [DATA_W-1:0] ex_rs1_data_o, ex_rs2_data_o, ex_imm_o;
   logic [9:0]        ex_funct_o;
   logic [REG_W-1:0]  ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o;
   logic              stall_o, pc_write_o, ifid_write_o;

   modport master (
      output start_i, op_i, ALUOp_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i,
             RegWrite_i, MemtoReg_i, rs1_data_i, rs2_data_i, imm_i, funct_i,
             rs1_addr_i, rs2_addr_i, rd_addr_i, flush_i,
      input  ex_ALUOp_o, ex_ALUSrc_o, ex_Branch_o, ex_MemRead_o, ex_MemWrite_o,
             ex_RegWrite_o, ex_MemtoReg_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
             ex_funct_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
             stall_o, pc_write_o, ifid_write_o
   );

   modport slave (
      input  start_i, op_i, ALUOp_i, ALUSrc_i, Branch_i, MemRead_i, MemWrite_i,
             RegWrite_i, MemtoReg_i, rs1_data_i, rs2_data_i, imm_i, funct_i,
             rs1_addr_i, rs2_addr_i, rd_addr_i, flush_i,
      output ex_ALUOp_o, ex_ALUSrc_o, ex_Branch_o, ex_MemRead_o, ex_MemWrite_o,
             ex_RegWrite_o, ex_MemtoReg_o, ex_rs1_data_o, ex_rs2_data_o, ex_imm_o,
             ex_funct_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
             stall_o, pc_write_o, ifid_write_o
   );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX register with load-use bubble insertion; 1-cycle ID->EX latency, +1 cycle per load-use pair.
// Optional HAZARD_STALL_CNT_EN adds a saturating 32-bit stall counter output.
module id_ex_hazard_reg #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5
) (
   input  logic                clk_i,
   input  logic                rst_i,
   id_ex_hazard_reg_if.slave   bus
`ifdef HAZARD_STALL_CNT_EN
   ,
   output logic [31:0]         stall_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, STALL} state_t;

   state_t state;
   logic   rs2_used;
   logic   rd_match;
   logic   hazard;
   logic   bubble;

   assign rs2_used = (bus.op_i == 7'b0110011) || (bus.op_i == 7'b0100011) ||
                     (bus.op_i == 7'b1100011);
   assign rd_match = (bus.ex_rd_addr_o == bus.rs1_addr_i) ||
                     (rs2_used && (bus.ex_rd_addr_o == bus.rs2_addr_i));

   // In STALL the EX slot already holds the bubble, so detection is masked.
   assign hazard = (state == RUN) && bus.ex_MemRead_o && (bus.ex_rd_addr_o != '0) &&
                   rd_match && !bus.flush_i;
   assign bubble = (state == IDLE) || hazard || bus.flush_i;

   assign bus.stall_o      = hazard;
   assign bus.pc_write_o   = (state != IDLE) && !hazard;
   assign bus.ifid_write_o = (state != IDLE) && !hazard;

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state             <= IDLE;
         bus.ex_ALUOp_o    <= '0;
         bus.ex_ALUSrc_o   <= 1'b0;
         bus.ex_Branch_o   <= 1'b0;
         bus.ex_MemRead_o  <= 1'b0;
         bus.ex_MemWrite_o <= 1'b0;
         bus.ex_RegWrite_o <= 1'b0;
         bus.ex_MemtoReg_o <= 1'b0;
         bus.ex_rs1_data_o <= '0;
         bus.ex_rs2_data_o <= '0;
         bus.ex_imm_o      <= '0;
         bus.ex_funct_o    <= '0;
         bus.ex_rs1_addr_o <= '0;
         bus.ex_rs2_addr_o <= '0;
         bus.ex_rd_addr_o  <= '0;
      end else begin
         case (state)
            IDLE:    if (bus.start_i) state <= RUN;
            RUN:     if (hazard) state <= STALL;
            STALL:   state <= RUN;
            default: state <= IDLE;
         endcase

         bus.ex_ALUOp_o    <= bubble ? 2'b00 : bus.ALUOp_i;
         bus.ex_ALUSrc_o   <= bubble ? 1'b0  : bus.ALUSrc_i;
         bus.ex_Branch_o   <= bubble ? 1'b0  : bus.Branch_i;
         bus.ex_MemRead_o  <= bubble ? 1'b0  : bus.MemRead_i;
         bus.ex_MemWrite_o <= bubble ? 1'b0  : bus.MemWrite_i;
         bus.ex_RegWrite_o <= bubble ? 1'b0  : bus.RegWrite_i;
         bus.ex_MemtoReg_o <= bubble ? 1'b0  : bus.MemtoReg_i;

         // Datapath fields always load so they stay deterministic under a bubble.
         bus.ex_rs1_data_o <= bus.rs1_data_i;
         bus.ex_rs2_data_o <= bus.rs2_data_i;
         bus.ex_imm_o      <= bus.imm_i;
         bus.ex_funct_o    <= bus.funct_i;
         bus.ex_rs1_addr_o <= bus.rs1_addr_i;
         bus.ex_rs2_addr_o <= bus.rs2_addr_i;
         bus.ex_rd_addr_o  <= bus.rd_addr_i;
      end
   end

`ifdef HAZARD_STALL_CNT_EN
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_o <= '0;
      end else if (hazard && (stall_cnt_o != 32'hFFFF_FFFF)) begin
         stall_cnt_o <= stall_cnt_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_id_ex_hazard_reg.sv
// Bench for id_ex_hazard_reg: directed load-use scenarios followed by random traffic,
// all checked each cycle against a behavioural pipeline model.
module tb_id_ex_hazard_reg;

   typedef struct packed {
      logic [7:0]  ctl;   // {ALUOp[1:0], ALUSrc, Branch, MemRead, MemWrite, RegWrite, MemtoReg}
      logic [31:0] rs1d;
      logic [31:0] rs2d;
      logic [31:0] imm;
      logic [9:0]  funct;
      logic [4:0]  a1;
      logic [4:0]  a2;
      logic [4:0]  rd;
   } ex_t;

   localparam logic [6:0] OP_LW   = 7'b0000011;
   localparam logic [6:0] OP_ADD  = 7'b0110011;
   localparam logic [6:0] OP_ADDI = 7'b0010011;
   localparam logic [6:0] OP_SW   = 7'b0100011;
   localparam logic [6:0] OP_BEQ  = 7'b1100011;
   localparam logic [7:0] C_LW    = 8'b00_1_0_1_0_1_1;
   localparam logic [7:0] C_ADD   = 8'b10_0_0_0_0_1_0;
   localparam logic [7:0] C_ADDI  = 8'b10_1_0_0_0_1_0;
   localparam logic [7:0] C_SW    = 8'b00_1_0_0_1_0_0;

   logic clk;
   logic rst;
   id_ex_hazard_reg_if #(.DATA_W(32), .REG_W(5)) bus ();
`ifdef HAZARD_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   id_ex_hazard_reg #(.DATA_W(32), .REG_W(5)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
`ifdef HAZARD_STALL_CNT_EN
      ,
      .stall_cnt_o (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Stimulus for the next cycle
   logic       i_rst, i_start, i_flush;
   logic [6:0] i_op;
   ex_t        i_id;

   // Model: what EX holds, whether the pipe has been started, whether the
   // last edge inserted a load-use bubble, and the number of stalls seen.
   ex_t         m_ex, nx_ex;
   logic        m_run, nx_run, m_bub, nx_bub;
   logic [31:0] m_cnt, nx_cnt;
   logic        e_stall, e_pcw;

   task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic ex_t dut_ex();
      ex_t e;
      e.ctl   = {bus.ex_ALUOp_o, bus.ex_ALUSrc_o, bus.ex_Branch_o, bus.ex_MemRead_o,
                 bus.ex_MemWrite_o, bus.ex_RegWrite_o, bus.ex_MemtoReg_o};
      e.rs1d  = bus.ex_rs1_data_o;
      e.rs2d  = bus.ex_rs2_data_o;
      e.imm   = bus.ex_imm_o;
      e.funct = bus.ex_funct_o;
      e.a1    = bus.ex_rs1_addr_o;
      e.a2    = bus.ex_rs2_addr_o;
      e.rd    = bus.ex_rd_addr_o;
      return e;
   endfunction

   task automatic model_reset();
      m_ex = '0;  nx_ex = '0;
      m_run = 0;  nx_run = 0;
      m_bub = 0;  nx_bub = 0;
      m_cnt = '0; nx_cnt = '0;
   endtask

   task automatic set_id(input logic [6:0] op, input logic [7:0] ctl, input logic [4:0] a1,
                         input logic [4:0] a2, input logic [4:0] rd, input logic flush);
      i_op       = op;
      i_id.ctl   = ctl;
      i_id.a1    = a1;
      i_id.a2    = a2;
      i_id.rd    = rd;
      i_id.rs1d  = $urandom;
      i_id.rs2d  = $urandom;
      i_id.imm   = $urandom;
      i_id.funct = 10'($urandom_range(0, 1023));
      i_flush    = flush;
   endtask

   // One clock: commit model at the edge, drive new inputs at the falling edge,
   // then check every output against the model.
   task automatic cyc();
      logic rs2u, dep;
      @(posedge clk);
      m_ex = nx_ex; m_run = nx_run; m_bub = nx_bub; m_cnt = nx_cnt;
      @(negedge clk);
      rst            = i_rst;
      bus.start_i    = i_start;
      bus.op_i       = i_op;
      {bus.ALUOp_i, bus.ALUSrc_i, bus.Branch_i, bus.MemRead_i, bus.MemWrite_i,
       bus.RegWrite_i, bus.MemtoReg_i} = i_id.ctl;
      bus.rs1_data_i = i_id.rs1d;
      bus.rs2_data_i = i_id.rs2d;
      bus.imm_i      = i_id.imm;
      bus.funct_i    = i_id.funct;
      bus.rs1_addr_i = i_id.a1;
      bus.rs2_addr_i = i_id.a2;
      bus.rd_addr_i  = i_id.rd;
      bus.flush_i    = i_flush;
      #1;
      rs2u    = (i_op == OP_ADD) || (i_op == OP_SW) || (i_op == OP_BEQ);
      dep     = m_ex.ctl[3] && (m_ex.rd != 0) &&
                ((m_ex.rd == i_id.a1) || (rs2u && (m_ex.rd == i_id.a2)));
      e_stall = rst && m_run && !m_bub && dep && !i_flush;
      e_pcw   = rst && m_run && !e_stall;
      chk("stall", 160'(bus.stall_o), 160'(e_stall));
      chk("pc_write", 160'(bus.pc_write_o), 160'(e_pcw));
      chk("ifid_write", 160'(bus.ifid_write_o), 160'(e_pcw));
      chk("ex_bundle", 160'(dut_ex()), 160'(m_ex));
`ifdef HAZARD_STALL_CNT_EN
      chk("stall_cnt", 160'(stall_cnt), 160'(m_cnt));
`endif
      if (!rst) begin
         model_reset();
      end else begin
         nx_ex     = i_id;
         nx_ex.ctl = (m_run && !e_stall && !i_flush) ? i_id.ctl : 8'h00;
         nx_run    = m_run || i_start;
         nx_bub    = e_stall;
         nx_cnt    = (e_stall && m_cnt != 32'hFFFF_FFFF) ? m_cnt + 32'd1 : m_cnt;
      end
   endtask

   // Asynchronous reset dropped in the middle of a cycle; released at the next falling edge.
   task automatic reset_pulse();
      rst = 1'b0;
      #1;
      chk("rst_ex_zero", 160'(dut_ex()), 160'h0);
      chk("rst_pcw_zero", 160'(bus.pc_write_o), 160'h0);
`ifdef HAZARD_STALL_CNT_EN
      chk("rst_cnt_zero", 160'(stall_cnt), 160'h0);
`endif
      model_reset();
      i_rst = 1'b1;
   endtask

   initial begin
      logic [6:0] ops [6];
      ops[0] = OP_LW; ops[1] = OP_ADD; ops[2] = OP_ADDI;
      ops[3] = OP_SW; ops[4] = OP_BEQ; ops[5] = 7'b0110111;

      rst = 1'b0; i_rst = 1'b0; i_start = 1'b0;
      set_id(7'h00, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
      model_reset();
      cyc(); cyc();
      chk("reset_ex", 160'(dut_ex()), 160'h0);
      chk("reset_pcw", 160'(bus.pc_write_o), 160'h0);

      // Start
      i_rst = 1'b1; i_start = 1'b1;
      cyc();
      chk("idle_pcw", 160'(bus.pc_write_o), 160'h0);
      i_start = 1'b0;
      cyc();
      chk("start_pcw", 160'(bus.pc_write_o), 160'h1);

      // Load-use on rs1
      set_id(OP_LW, C_LW, 5'd1, 5'd0, 5'd5, 1'b0);  cyc();
      set_id(OP_ADD, C_ADD, 5'd5, 5'd3, 5'd7, 1'b0); cyc();
      chk("lu_stall", 160'(bus.stall_o), 160'h1);
      chk("lu_pcw", 160'(bus.pc_write_o), 160'h0);
      chk("lu_ifidw", 160'(bus.ifid_write_o), 160'h0);
      cyc();
      chk("lu_bubble", 160'(dut_ex().ctl), 160'h0);
      chk("lu_nostall", 160'(bus.stall_o), 160'h0);
      set_id(7'h00, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0); cyc();
      chk("lu_regwrite", 160'(bus.ex_RegWrite_o), 160'h1);
      chk("lu_rs1addr", 160'(bus.ex_rs1_addr_o), 160'd5);

      // Reset mid-run, then restart
      reset_pulse();
      i_start = 1'b1; cyc();
      chk("restart_idle_pcw", 160'(bus.pc_write_o), 160'h0);
      i_start = 1'b0; cyc();
      chk("restart_pcw", 160'(bus.pc_write_o), 160'h1);

      // x0 destination never stalls
      set_id(OP_LW, C_LW, 5'd1, 5'd0, 5'd0, 1'b0);  cyc();
      set_id(OP_ADD, C_ADD, 5'd0, 5'd0, 5'd7, 1'b0); cyc();
      chk("x0_stall", 160'(bus.stall_o), 160'h0);

      // rs2 ignored for addi, honoured for sw
      set_id(OP_LW, C_LW, 5'd1, 5'd0, 5'd5, 1'b0);    cyc();
      set_id(OP_ADDI, C_ADDI, 5'd1, 5'd5, 5'd8, 1'b0); cyc();
      chk("addi_stall", 160'(bus.stall_o), 160'h0);
      set_id(OP_LW, C_LW, 5'd1, 5'd0, 5'd5, 1'b0); cyc();
      set_id(OP_SW, C_SW, 5'd1, 5'd5, 5'd0, 1'b0); cyc();
      chk("sw_stall", 160'(bus.stall_o), 160'h1);
      cyc();
      chk("sw_stall_state", 160'(bus.stall_o), 160'h0);

      // Flush beats hazard
      set_id(OP_LW, C_LW, 5'd1, 5'd0, 5'd5, 1'b0);  cyc();
      set_id(OP_ADD, C_ADD, 5'd5, 5'd3, 5'd7, 1'b1); cyc();
      chk("flush_stall", 160'(bus.stall_o), 160'h0);
      chk("flush_pcw", 160'(bus.pc_write_o), 160'h1);
      set_id(7'h00, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0); cyc();
      chk("flush_bubble", 160'(dut_ex().ctl), 160'h0);
      chk("flush_pcw_after", 160'(bus.pc_write_o), 160'h1);

      // Back-to-back loads: lw x5; lw x6,(x5); add x7,x6,x2
      set_id(OP_LW, C_LW, 5'd1, 5'd0, 5'd5, 1'b0); cyc();
      chk("b2b_first", 160'(bus.stall_o), 160'h0);
      set_id(OP_LW, C_LW, 5'd5, 5'd0, 5'd6, 1'b0); cyc();
      chk("b2b_stall1", 160'(bus.stall_o), 160'h1);
      cyc();
      chk("b2b_hold1", 160'(bus.stall_o), 160'h0);
      set_id(OP_ADD, C_ADD, 5'd6, 5'd2, 5'd7, 1'b0); cyc();
      chk("b2b_stall2", 160'(bus.stall_o), 160'h1);
      cyc();
      chk("b2b_hold2", 160'(bus.stall_o), 160'h0);
      set_id(7'h00, 8'h00, 5'd0, 5'd0, 5'd0, 1'b0); cyc();
`ifdef HAZARD_STALL_CNT_EN
      chk("cnt_three", 160'(stall_cnt), 160'd3);
`endif

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         set_id(ops[$urandom_range(0, 5)], 8'($urandom), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
         i_start = ($urandom_range(0, 3) == 0);
         cyc();
         if ($urandom_range(0, 199) == 0) reset_pulse();
      end

      reset_pulse();
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
